fx_mul_seq: RTL and testbench

//  Iterative signed fixed-point multiplier, QINT.QFRAC in and out; the inverse-operation partner of the pipelined divider.

---
 rtl/fx_mul_seq_if.sv | 25 ++
 rtl/fx_mul_seq.sv | 124 ++++++++++++
 tb/tb_fx_mul_seq.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/fx_mul_seq_if.sv
// Operand/result bundle for the iterative fixed-point multiplier.
// Valid/ready on both sides: a beat moves on a rising edge where valid and ready are both high;
// the source holds its valid and payload stable until that edge, and ready never waits on valid.
interface fx_mul_seq_if #(
  parameter int WIDTH = 32
);
  logic             valid_in;
  logic             ready_in;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             valid_out;
  logic             ready_out;
  logic [WIDTH-1:0] result;
  logic             overflow;

  modport master (
    output valid_in, a, b, ready_out,
    input  ready_in, valid_out, result, overflow
  );

  modport slave (
    input  valid_in, a, b, ready_out,
    output ready_in, valid_out, result, overflow
  );
endinterface

// File: rtl/fx_mul_seq.sv
// Radix-2 shift-add signed Q-format multiplier with saturation, one operand pair in flight.
// Optional FX_MUL_ROUND_EN: round half away from zero instead of truncating toward zero.
module fx_mul_seq #(
  parameter int WIDTH = 32,
  parameter int QINT  = 16,
  parameter int QFRAC = 16
) (
  input  logic         clk,
  input  logic         rst,
  fx_mul_seq_if.slave  bus,
  output logic [1:0]   dbg_state
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
  localparam logic [2*WIDTH-1:0] POS_MAX = {{(WIDTH + 1){1'b0}}, {(WIDTH - 1){1'b1}}};
  localparam logic [2*WIDTH-1:0] NEG_MAG = POS_MAX + 1'b1;

  if (QINT + QFRAC != WIDTH || QFRAC < 1 || WIDTH < 4) begin : g_bad_cfg
    $error("fx_mul_seq: need QINT+QFRAC == WIDTH, QFRAC >= 1, WIDTH >= 4");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state;
  logic                 sign;
  logic [WIDTH-1:0]     mcand;
  logic [WIDTH-1:0]     mplier;
  logic [2*WIDTH-1:0]   acc;
  logic [CW-1:0]        cnt;

  logic [WIDTH-1:0]     abs_a;
  logic [WIDTH-1:0]     abs_b;
  logic [2*WIDTH-1:0]   acc_next;
  logic [2*WIDTH-1:0]   mag;
  logic [WIDTH-1:0]     sat_result;
  logic                 sat_ovf;

  assign dbg_state = state;

  // Magnitudes are unsigned WIDTH bits so the most negative operand maps to 2^(WIDTH-1).
  assign abs_a = bus.a[WIDTH-1] ? (~bus.a + 1'b1) : bus.a;
  assign abs_b = bus.b[WIDTH-1] ? (~bus.b + 1'b1) : bus.b;

  always_comb begin
    acc_next = acc;
    if (mplier[0]) begin
      acc_next = acc + ({{WIDTH{1'b0}}, mcand} << cnt);
    end
`ifdef FX_MUL_ROUND_EN
    mag = (acc_next + ({{(2*WIDTH-1){1'b0}}, 1'b1} << (QFRAC - 1))) >> QFRAC;
`else
    mag = acc_next >> QFRAC;
`endif
    sat_result = mag[WIDTH-1:0];
    sat_ovf    = 1'b0;
    if (sign) begin
      if (mag > NEG_MAG) begin
        sat_result = {1'b1, {(WIDTH - 1){1'b0}}};
        sat_ovf    = 1'b1;
      end else begin
        // Negating a zero magnitude stays zero, so no negative zero escapes.
        sat_result = ~mag[WIDTH-1:0] + 1'b1;
      end
    end else if (mag > POS_MAX) begin
      sat_result = {1'b0, {(WIDTH - 1){1'b1}}};
      sat_ovf    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      bus.ready_in  <= 1'b0;
      bus.valid_out <= 1'b0;
      bus.result    <= '0;
      bus.overflow  <= 1'b0;
      sign          <= 1'b0;
      mcand         <= '0;
      mplier        <= '0;
      acc           <= '0;
      cnt           <= '0;
    end else begin
      case (state)
        IDLE: begin
          bus.ready_in <= 1'b1;
          if (bus.valid_in && bus.ready_in) begin
            sign         <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
            mcand        <= abs_a;
            mplier       <= abs_b;
            acc          <= '0;
            cnt          <= '0;
            bus.ready_in <= 1'b0;
            state        <= CALC;
          end
        end
        CALC: begin
          acc    <= acc_next;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST_CNT) begin
            bus.result    <= sat_result;
            bus.overflow  <= sat_ovf;
            bus.valid_out <= 1'b1;
            state         <= DONE;
          end
        end
        DONE: begin
          if (bus.ready_out) begin
            bus.valid_out <= 1'b0;
            bus.ready_in  <= 1'b1;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fx_mul_seq.sv
// Directed bench for fx_mul_seq in Q16.16; inputs driven and outputs sampled on the falling edge.
module tb_fx_mul_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] dbg_state;
  int         checks = 0;
  int         passes = 0;
  int         fails  = 0;

  fx_mul_seq_if #(.WIDTH(32)) bus ();

  fx_mul_seq #(.WIDTH(32), .QINT(16), .QFRAC(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: observed no finish, expected finish before 400000 time units");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Returns at the falling edge just after the accepting rising edge.
  task automatic send(input string tag, input logic [31:0] a, input logic [31:0] b);
    logic taken;
    taken = 1'b0;
    bus.a = a;
    bus.b = b;
    bus.valid_in = 1'b1;
    for (int i = 0; i < 100; i++) begin
      taken = bus.ready_in;
      tick();
      if (taken) break;
    end
    bus.valid_in = 1'b0;
    if (!taken) check({tag, "_accept_timeout"}, 32'd0, 32'd1);
  endtask

  // lat = index of the first rising edge (counting from 1 after accept) that sees valid_out high.
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!bus.valid_out && lat < 200) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic expect_result(input string tag, input logic [31:0] exp_res, input logic exp_ovf);
    int lat;
    wait_valid(lat);
    check({tag, "_valid"}, 32'(bus.valid_out), 32'd1);
    check({tag, "_result"}, bus.result, exp_res);
    check({tag, "_overflow"}, 32'(bus.overflow), 32'(exp_ovf));
    bus.ready_out = 1'b1;
    tick();
    bus.ready_out = 1'b0;
    check({tag, "_valid_drop"}, 32'(bus.valid_out), 32'd0);
    check({tag, "_ready_back"}, 32'(bus.ready_in), 32'd1);
  endtask

  initial begin
    int   lat;
    logic seen_valid;
    logic [31:0] held_res;
    bus.valid_in  = 1'b0;
    bus.ready_out = 1'b0;
    bus.a = '0;
    bus.b = '0;

    // Reset values
    tick();
    tick();
    check("rst_ready_in", 32'(bus.ready_in), 32'd0);
    check("rst_valid_out", 32'(bus.valid_out), 32'd0);
    check("rst_result", bus.result, 32'd0);
    check("rst_overflow", 32'(bus.overflow), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    rst = 1'b0;
    tick();
    check("post_rst_ready_in", 32'(bus.ready_in), 32'd1);

    // 1.5 * 2.0 with latency measurement
    send("t1", 32'h0001_8000, 32'h0002_0000);
    check("t1_state_calc", 32'(dbg_state), 32'd1);
    wait_valid(lat);
    check("t1_latency", 32'(lat), 32'd33);
    expect_result("t1", 32'h0003_0000, 1'b0);

    // Signs and saturation
    send("t2a", 32'hFFFE_8000, 32'h0002_0000);
    expect_result("t2a", 32'hFFFD_0000, 1'b0);
    send("t2b", 32'h8000_0000, 32'h8000_0000);
    expect_result("t2b", 32'h7FFF_FFFF, 1'b1);
    send("t3a", 32'h7FFF_0000, 32'h0002_0000);
    expect_result("t3a", 32'h7FFF_FFFF, 1'b1);
    send("t3b", 32'h7FFF_0000, 32'hFFFE_0000);
    expect_result("t3b", 32'h8000_0000, 1'b1);
    // Exactly -2^15 fits without clamping
    send("t3c", 32'h8000_0000, 32'h0001_0000);
    expect_result("t3c", 32'h8000_0000, 1'b0);
    // Zero product with a negative operand is plain zero
    send("t3d", 32'h0000_0000, 32'hFFFF_0000);
    expect_result("t3d", 32'h0000_0000, 1'b0);

    // Rounding vs truncation of one LSB times one half
`ifdef FX_MUL_ROUND_EN
    send("t4a", 32'h0000_0001, 32'h0000_8000);
    expect_result("t4a", 32'h0000_0001, 1'b0);
    send("t4b", 32'hFFFF_FFFF, 32'h0000_8000);
    expect_result("t4b", 32'hFFFF_FFFF, 1'b0);
`else
    send("t4a", 32'h0000_0001, 32'h0000_8000);
    expect_result("t4a", 32'h0000_0000, 1'b0);
    send("t4b", 32'hFFFF_FFFF, 32'h0000_8000);
    expect_result("t4b", 32'h0000_0000, 1'b0);
`endif

    // Backpressure: 2.5 * -1.0 held in DONE while a new pair waits upstream
    send("t5", 32'h0002_8000, 32'hFFFF_0000);
    wait_valid(lat);
    held_res = bus.result;
    check("t5_result", held_res, 32'hFFFD_8000);
    bus.a = 32'h0003_0000;
    bus.b = 32'h0000_4000;
    bus.valid_in = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t5_hold_valid", 32'(bus.valid_out), 32'd1);
      check("t5_hold_result", bus.result, held_res);
      check("t5_hold_overflow", 32'(bus.overflow), 32'd0);
      check("t5_hold_ready_in", 32'(bus.ready_in), 32'd0);
    end
    bus.ready_out = 1'b1;
    tick();
    bus.ready_out = 1'b0;
    check("t5_release_valid", 32'(bus.valid_out), 32'd0);
    check("t5_release_ready_in", 32'(bus.ready_in), 32'd1);
    tick();
    bus.valid_in = 1'b0;
    check("t5_next_accepted", 32'(bus.ready_in), 32'd0);
    check("t5_next_state", 32'(dbg_state), 32'd1);
    // 3.0 * 0.25
    expect_result("t5_next", 32'h0000_C000, 1'b0);

    // Reset in the middle of CALC discards the pair
    send("t6", 32'h0001_8000, 32'h0002_0000);
    for (int i = 0; i < 10; i++) tick();
    check("t6_mid_state", 32'(dbg_state), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_rst_ready_in", 32'(bus.ready_in), 32'd0);
    check("t6_rst_state", 32'(dbg_state), 32'd0);
    seen_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.valid_out) seen_valid = 1'b1;
      tick();
    end
    check("t6_no_valid", 32'(seen_valid), 32'd0);
    send("t6_new", 32'h0002_0000, 32'h0003_0000);
    expect_result("t6_new", 32'h0006_0000, 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
